mul_seq: RTL and testbench

Iterative multiply sequencer for the execute stage of the 64-bit pipelined core. When the EX stage holds a MUL instruction, it latches both operands and runs a radix-2 shift-add multiply, one multiplier bit per cycle, with early exit on the remaining multiplier bits. While it runs it stalls the IF/ID/EX pipeline registers. When it finishes it presents the low N bits of the product to the EX/MEM boundary for one cycle.

---
 rtl/mul_seq.sv | 142 ++++++++++++++
 tb/tb_mul_seq.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mul_seq.sv
// -----------------------------------------------------------------------------
// mul_seq
//
// Iterative multiply sequencer for the execute stage. A MUL held in EX is
// accepted from IDLE: both operands are latched and a radix-2 shift-add
// multiply runs one multiplier bit per cycle. It exits early once the
// remaining multiplier bits are all zero. While the multiply is accepted or
// running, the front of the pipeline is stalled. The low N bits of the
// product are presented for one cycle in DONE.
//
// Handshake: start_E is a level request. It is held by the pipeline while
// stall_E is high. It is consumed only in IDLE, and only when flush_E is low.
// done_E is a single-cycle pulse, and result_E is meaningful only while
// done_E is high. flush_E aborts whatever is in flight at the next edge.
//
// Ports
//   clk        pipeline clock, rising edge
//   reset      asynchronous, active-high; clears state and all datapath regs
//   start_E    EX holds a valid MUL
//   flush_E    EX instruction squashed; abort, no done_E for it
//   opA_E      multiplicand
//   opB_E      multiplier
//   stall_E    freeze PC, IF/ID, ID/EX this cycle
//   busy       state is not IDLE
//   done_E     one-cycle completion pulse
//   result_E   product mod 2^N
//   state_dbg  current FSM state, for observation only
// -----------------------------------------------------------------------------
module mul_seq #(
    parameter int unsigned N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start_E,
    input  logic         flush_E,
    input  logic [N-1:0] opA_E,
    input  logic [N-1:0] opB_E,
    output logic         stall_E,
    output logic         busy,
    output logic         done_E,
    output logic [N-1:0] result_E,
    output logic [1:0]   state_dbg
);

    // cnt must be able to hold the value N itself.
    localparam int unsigned CW = $clog2(N) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  mcand_q, mcand_d;
    logic [N-1:0]  mplier_q, mplier_d;
    logic [N-1:0]  acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc;

    assign cnt_inc = cnt_q + CW'(1);

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and datapath update
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;

        if (flush_E) begin
            // The datapath is left as-is. It is reloaded at the next acceptance.
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_E) begin
                        mcand_d  = opA_E;
                        mplier_d = opB_E;
                        acc_d    = '0;
                        cnt_d    = '0;
                        // A zero multiplier finishes with no RUN cycles.
                        state_d  = (opB_E != '0) ? RUN : DONE;
                    end
                end
                RUN: begin
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;   // carry-out discarded
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_inc;
                    // Stop early once no multiplier bits are left.
                    if ((mplier_d == '0) || (cnt_inc == CW'(N))) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    // A start_E seen here still belongs to the retiring MUL.
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // Reset gates stall_E so that it is low for as long as reset is held,
    // even while a MUL still sits in EX.
    assign stall_E   = ~reset & ~flush_E &
                       (((state_q == IDLE) & start_E) | (state_q == RUN));
    assign busy      = (state_q != IDLE);
    assign done_E    = (state_q == DONE);
    assign result_E  = acc_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_mul_seq.sv
module tb_mul_seq;

    localparam int N = 64;

    logic         clk;
    logic         reset;
    logic         start_E;
    logic         flush_E;
    logic [N-1:0] opA_E;
    logic [N-1:0] opB_E;
    logic         stall_E;
    logic         busy;
    logic         done_E;
    logic [N-1:0] result_E;
    logic [1:0]   state_dbg;

    logic [N-1:0] exp_q[$];
    int           n_cmp;
    int           n_bad;

    mul_seq #(.N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .start_E   (start_E),
        .flush_E   (flush_E),
        .opA_E     (opA_E),
        .opB_E     (opB_E),
        .stall_E   (stall_E),
        .busy      (busy),
        .done_E    (done_E),
        .result_E  (result_E),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: every done_E pulse must match the oldest pending product.
    always @(negedge clk) begin
        if (!reset && done_E) begin
            if (exp_q.size() == 0) begin
                check("spurious_done", 64'(done_E), 64'd0);
            end else begin
                check("result", result_E, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Number of RUN cycles: one per multiplier bit up to the highest set bit.
    function automatic int top_k(input logic [N-1:0] b);
        int k;
        k = 0;
        for (int i = 0; i < N; i++) if (b[i]) k = i + 1;
        return k;
    endfunction

    // Presents a MUL starting this cycle (t0) and checks the per-cycle
    // stall/busy/done profile through the DONE cycle. start_E is held for the
    // whole time the MUL is in EX, DONE included. With scramble set, the
    // operand inputs are changed during t1..t2.
    task automatic do_mul(input logic [N-1:0] a, input logic [N-1:0] b,
                          input bit scramble, input bit keep_start);
        int k;
        k = top_k(b);
        start_E = 1'b1;
        opA_E   = a;
        opB_E   = b;
        exp_q.push_back(a * b);
        for (int c = 0; c <= k + 1; c++) begin
            @(negedge clk);
            check($sformatf("stall_t%0d", c), 64'(stall_E), 64'(c <= k));
            check($sformatf("busy_t%0d", c),  64'(busy),    64'(c >= 1));
            check($sformatf("done_t%0d", c),  64'(done_E),  64'(c == k + 1));
            tick();
            if (scramble && c < 2) begin
                opA_E = {$urandom, $urandom};
                opB_E = {$urandom, $urandom};
            end
        end
        if (!keep_start) start_E = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        reset   = 1'b1;
        start_E = 1'b0;
        flush_E = 1'b0;
        opA_E   = '0;
        opB_E   = '0;

        #12;
        check("rst_stall",  64'(stall_E), 64'd0);
        check("rst_busy",   64'(busy),    64'd0);
        check("rst_done",   64'(done_E),  64'd0);
        check("rst_result", result_E,     64'd0);
        tick();
        reset = 1'b0;
        tick();

        // Reset in the middle of RUN.
        start_E = 1'b1; opA_E = 64'd7; opB_E = 64'hFF;
        tick(); tick(); tick();             // now in t3
        reset = 1'b1;
        #1;
        check("midrst_stall",  64'(stall_E), 64'd0);
        check("midrst_busy",   64'(busy),    64'd0);
        check("midrst_done",   64'(done_E),  64'd0);
        check("midrst_result", result_E,     64'd0);
        start_E = 1'b0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("postrst_busy", 64'(busy),   64'd0);
            check("postrst_done", 64'(done_E), 64'd0);
            tick();
        end

        // Basic multiplies.
        do_mul(64'd3, 64'd5, 1'b0, 1'b0);
        tick();
        do_mul(64'hFFFF, 64'd0, 1'b0, 1'b0);
        tick();
        do_mul(64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b0, 1'b0);
        tick();

        // Flush in the middle of RUN (t2).
        start_E = 1'b1; opA_E = 64'd7; opB_E = 64'hFF;
        tick(); tick();                     // t2
        flush_E = 1'b1;
        @(negedge clk);
        check("flush_stall", 64'(stall_E), 64'd0);
        tick();                             // t3
        flush_E = 1'b0;
        start_E = 1'b0;
        @(negedge clk);
        check("flush_busy", 64'(busy),   64'd0);
        check("flush_done", 64'(done_E), 64'd0);
        tick();                             // t4
        @(negedge clk);
        check("flush_idle", 64'(busy),   64'd0);
        tick();                             // t5
        do_mul(64'd2, 64'd2, 1'b0, 1'b0);
        tick();

        // Back-to-back, with the operand inputs changed mid-run.
        do_mul(64'd6, 64'd3, 1'b1, 1'b1);
        do_mul(64'd4, 64'd1, 1'b0, 1'b0);
        tick();

        // A few random operands with bounded multiplier width.
        for (int i = 0; i < 4; i++) begin
            logic [N-1:0] a, b;
            a = {$urandom, $urandom};
            b = 64'($urandom_range(1, 4095));
            do_mul(a, b, 1'b0, (i < 3));
        end

        tick(); tick();
        check("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
